audio_packet_unpacker: RTL and testbench
========================================

// Module: audio_packet_unpacker
// PURPOSE
//   Sink-side counterpart of the audio sample buffer: accepts audio sample packets carrying up to
//   PARALLEL_IN samples each, stores them in a circular FIFO and emits one sample per audio_tick.
//   Sits after the HDMI audio packet decoder in the receive path, all in the clk_pixel domain.
//   audio_tick is a 1-cycle strobe at the audio sample rate. The FIFO absorbs packet burstiness.
// PARAMETERS
//   BUFFER_SIZE  128  FIFO depth in samples; power of 2, >= 2*PARALLEL_IN
//   BIT_WIDTH    16   bits per channel sample
//   CHANNELS     2    channels per sample
//   PARALLEL_IN  4    max samples per packet
//   PREFILL      8    level required before playback (re)starts; 1..BUFFER_SIZE-PARALLEL_IN
// PORTS
//   clk_pixel      in   1                              system clock
//   reset          in   1                              synchronous, active-high
//   packet_valid   in   1                              packet present this cycle
//   packet_count   in   3                              valid samples in packet, 0..PARALLEL_IN
//   packet_samples in   [PARALLEL_IN][CHANNELS][BIT_WIDTH]  index 0 = oldest
//   packet_ready   out  1                              FIFO free space >= PARALLEL_IN
//   audio_tick     in   1                              request one output sample
//   audio_out      out  [CHANNELS][BIT_WIDTH]          current output sample (registered)
//   audio_valid    out  1                              1-cycle pulse: audio_out newly loaded from FIFO
//   level          out  $clog2(BUFFER_SIZE)+1          samples held, 0..BUFFER_SIZE
//   overflow       out  1                              sticky: packet dropped
//   underflow      out  1                              sticky: tick with empty FIFO while RUN
//   status_clear   in   1                              clears overflow/underflow
// BEHAVIOUR
//   - Reset: pointers 0, level 0, state FILL, audio_out 0, audio_valid/overflow/underflow 0.
//     Reset mid-packet discards the packet and all stored samples; takes precedence over all inputs.
//   - Pointers are $clog2(BUFFER_SIZE)+1 bits; full = MSBs differ, rest equal; wrap mod BUFFER_SIZE.
//   - Write: if packet_valid && packet_ready, samples 0..n-1 stored at wr_ptr..wr_ptr+n-1 (wrapping),
//     n = min(packet_count, PARALLEL_IN); wr_ptr += n. n=0 is an accepted no-op.
//   - packet_valid && !packet_ready: packet dropped entirely, overflow <= 1. No partial writes.
//   - Written samples are readable from the next cycle; level updates 1 cycle after write.
//   - Simultaneous write and read: level_next = level + n - r (r = 0/1); both take effect.
//   - FSM states:
//       FILL: ticks ignored (no underflow, audio_out holds). -> RUN when level >= PREFILL.
//       RUN : on audio_tick with level > 0: audio_out <= fifo[rd_ptr], rd_ptr++, audio_valid
//             pulses next cycle. On audio_tick with level == 0: underflow <= 1, -> FILL,
//             audio_out per CONFIGURATION.
//   - Read latency: audio_tick at cycle T -> audio_out/audio_valid at T+1.
//   - status_clear clears sticky flags; a same-cycle new event wins (flag stays 1).
//   - packet_ready is combinational from registered level: level <= BUFFER_SIZE-PARALLEL_IN.
// CONFIGURATION
//   AUDIO_UNDERFLOW_MUTE_EN defined: on underflow audio_out <= 0 (silence) until next valid read.
//   Not defined: audio_out holds last sample on underflow. audio_valid never pulses on underflow.
// TESTING
//   1. Reset, packets of 4 samples 1..8 (2 packets), ticks -> RUN at level 8; out 1,2,3... each T+1.
//   2. Fill to 125, send count=4 -> packet_ready=0, packet dropped, overflow=1, level stays 125.
//   3. RUN with level 1: tick, tick -> second tick sets underflow, state FILL; audio_out=0 with
//      AUDIO_UNDERFLOW_MUTE_EN, else holds last sample; later ticks ignored until level >= 8.
//   4. wr_ptr at 126, packet count=4 values A..D -> stored at 126,127,0,1; read order A,B,C,D.
//   5. Same-cycle packet (count 3) and tick at level 10 -> level 12 next cycle; status_clear
//      with simultaneous overflow leaves overflow=1.
//   6. Reset asserted mid-stream at level 40 -> level 0, FILL, audio_out 0, flags 0 next cycle.

Source files
------------

// File: rtl/audio_packet_unpacker.sv
// Receive-side audio FIFO: stores decoded sample packets and plays them out one sample per audio_tick.
// Optional macro AUDIO_UNDERFLOW_MUTE_EN: output is forced to silence when the FIFO underflows.
module audio_packet_unpacker #(
    parameter int BUFFER_SIZE = 128,
    parameter int BIT_WIDTH   = 16,
    parameter int CHANNELS    = 2,
    parameter int PARALLEL_IN = 4,
    parameter int PREFILL     = 8
) (
    input  logic                                            clk_pixel,
    input  logic                                            reset,
    input  logic                                            packet_valid,
    input  logic [2:0]                                      packet_count,
    input  logic [PARALLEL_IN-1:0][CHANNELS-1:0][BIT_WIDTH-1:0] packet_samples,
    output logic                                            packet_ready,
    input  logic                                            audio_tick,
    output logic [CHANNELS-1:0][BIT_WIDTH-1:0]              audio_out,
    output logic                                            audio_valid,
    output logic [$clog2(BUFFER_SIZE):0]                    level,
    output logic                                            overflow,
    output logic                                            underflow,
    input  logic                                            status_clear
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int PW = AW + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [CHANNELS-1:0][BIT_WIDTH-1:0] mem_r [BUFFER_SIZE];
    logic [CHANNELS-1:0][BIT_WIDTH-1:0] audio_out_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] level_r;
    state_t        state_r;
    logic          audio_valid_r;
    logic          overflow_r;
    logic          underflow_r;

    logic [2:0]    cnt_s;
    logic [2:0]    wr_n_s;
    logic          ready_s;
    logic          drop_s;
    logic          rd_en_s;
    logic          starve_s;

    // Accept/drop decision and read/underflow qualification from registered level and state.
    always_comb begin
        if (packet_count > 3'(PARALLEL_IN)) begin
            cnt_s = 3'(PARALLEL_IN);
        end else begin
            cnt_s = packet_count;
        end
        ready_s  = (level_r <= PW'(BUFFER_SIZE - PARALLEL_IN));
        drop_s   = packet_valid && !ready_s;
        if (packet_valid && ready_s) begin
            wr_n_s = cnt_s;
        end else begin
            wr_n_s = 3'd0;
        end
        rd_en_s  = (state_r == RUN) && audio_tick && (level_r != '0);
        starve_s = (state_r == RUN) && audio_tick && (level_r == '0);
    end

    // Sample storage; the low pointer bits wrap naturally modulo the depth.
    always_ff @(posedge clk_pixel) begin
        for (int i = 0; i < PARALLEL_IN; i++) begin
            if (3'(i) < wr_n_s) begin
                mem_r[wr_ptr_r[AW-1:0] + AW'(i)] <= packet_samples[i];
            end
        end
    end

    // Pointers, level, sticky flags and playback state machine.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            level_r       <= '0;
            state_r       <= FILL;
            audio_out_r   <= '0;
            audio_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_r + PW'(wr_n_s);
            rd_ptr_r      <= rd_ptr_r + PW'(rd_en_s);
            level_r       <= level_r + PW'(wr_n_s) - PW'(rd_en_s);
            audio_valid_r <= rd_en_s;
            // A new event in the same cycle as status_clear keeps the flag set.
            overflow_r    <= drop_s | (overflow_r & ~status_clear);
            underflow_r   <= starve_s | (underflow_r & ~status_clear);
            case (state_r)
                FILL: begin
                    if (level_r >= PW'(PREFILL)) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en_s) begin
                        audio_out_r <= mem_r[rd_ptr_r[AW-1:0]];
                    end else if (starve_s) begin
                        state_r <= FILL;
`ifdef AUDIO_UNDERFLOW_MUTE_EN
                        audio_out_r <= '0;
`endif
                    end
                end
                default: begin
                    state_r <= FILL;
                end
            endcase
        end
    end

    assign packet_ready = ready_s;
    assign audio_out    = audio_out_r;
    assign audio_valid  = audio_valid_r;
    assign level        = level_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_audio_packet_unpacker.sv
// Bench for audio_packet_unpacker: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_audio_packet_unpacker;
    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  packet_valid = 1'b0;
    logic [2:0]            packet_count = 3'd0;
    logic [3:0][1:0][15:0] packet_samples = '0;
    logic                  packet_ready;
    logic                  audio_tick = 1'b0;
    logic [1:0][15:0]      audio_out;
    logic                  audio_valid;
    logic [7:0]            level;
    logic                  overflow;
    logic                  underflow;
    logic                  status_clear = 1'b0;

    int total = 0;
    int bad   = 0;
    bit en    = 1'b0;

    logic [31:0] q[$];
    bit          m_run;
    logic [31:0] m_out;
    bit          m_valid;
    bit          m_ovf;
    bit          m_und;

    audio_packet_unpacker dut (
        .clk_pixel      (clk),
        .reset          (reset),
        .packet_valid   (packet_valid),
        .packet_count   (packet_count),
        .packet_samples (packet_samples),
        .packet_ready   (packet_ready),
        .audio_tick     (audio_tick),
        .audio_out      (audio_out),
        .audio_valid    (audio_valid),
        .level          (level),
        .overflow       (overflow),
        .underflow      (underflow),
        .status_clear   (status_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int k);
        return {16'(k * 7 + 3), 16'(k)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, behaviour from the sample-level rules.
    initial begin : model
        int lvl;
        int n;
        bit rd;
        bit starve;
        m_run = 0; m_out = '0; m_valid = 0; m_ovf = 0; m_und = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_run = 0; m_out = '0; m_valid = 0; m_ovf = 0; m_und = 0;
            end else begin
                lvl    = q.size();
                rd     = m_run && audio_tick && (lvl > 0);
                starve = m_run && audio_tick && (lvl == 0);
                m_valid = rd;
                m_ovf = (packet_valid && lvl > 124) || (m_ovf && !status_clear);
                m_und = starve || (m_und && !status_clear);
                if (rd) m_out = q.pop_front();
                if (starve) begin
                    m_run = 0;
`ifdef AUDIO_UNDERFLOW_MUTE_EN
                    m_out = '0;
`endif
                end else if (!m_run && lvl >= 8) begin
                    m_run = 1;
                end
                if (packet_valid && lvl <= 124) begin
                    n = (packet_count > 3'd4) ? 4 : int'(packet_count);
                    for (int i = 0; i < n; i++) q.push_back(packet_samples[i]);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (en) begin
                chk("cyc_out",   audio_out, m_out);
                chk("cyc_valid", 32'(audio_valid), 32'(m_valid));
                chk("cyc_level", 32'(level), 32'(q.size()));
                chk("cyc_ready", 32'(packet_ready), 32'(q.size() <= 124));
                chk("cyc_ovf",   32'(overflow), 32'(m_ovf));
                chk("cyc_und",   32'(underflow), 32'(m_und));
            end
        end
    end

    task automatic cyc(input logic pv, input int cnt, input int base,
                       input logic tk, input logic clr, input logic rst);
        packet_valid = pv;
        packet_count = 3'(cnt);
        for (int i = 0; i < 4; i++) packet_samples[i] = mk(base + i);
        audio_tick   = tk;
        status_clear = clr;
        reset        = rst;
        @(posedge clk);
        #1;
        packet_valid = 1'b0;
        packet_count = 3'd0;
        audio_tick   = 1'b0;
        status_clear = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic send(input int cnt, input int base);
        cyc(1'b1, cnt, base, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : stim
        logic [31:0] exp_hold;
        int nxt;
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        en = 1'b1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out", audio_out, 32'd0);
        chk("rst_flags", {29'd0, audio_valid, overflow, underflow}, 32'd0);

        // Prefill with samples 1..8, then play out 1,2,3.
        send(4, 1);
        send(4, 5);
        chk("t1_level", 32'(level), 32'd8);
        idle();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_out", audio_out, mk(k));
            chk("t1_valid", 32'(audio_valid), 32'd1);
        end

        // Drain to empty, then one tick too many.
        for (int k = 4; k <= 8; k++) tick();
        chk("t3_last", audio_out, mk(8));
        chk("t3_level0", 32'(level), 32'd0);
        tick();
`ifdef AUDIO_UNDERFLOW_MUTE_EN
        exp_hold = 32'd0;
`else
        exp_hold = mk(8);
`endif
        chk("t3_und", 32'(underflow), 32'd1);
        chk("t3_out", audio_out, exp_hold);
        chk("t3_novalid", 32'(audio_valid), 32'd0);
        send(4, 50);
        tick();
        chk("t3_fill_ignore", 32'(level), 32'd4);
        chk("t3_fill_noval", 32'(audio_valid), 32'd0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("t3_clr", 32'(underflow), 32'd0);

        // Fill to 125, overflow, then wrap the write pointer past the end.
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        nxt = 100;
        for (int p = 0; p < 31; p++) begin
            send(4, nxt);
            nxt += 4;
        end
        send(1, nxt);
        nxt += 1;
        chk("t2_level", 32'(level), 32'd125);
        chk("t2_ready", 32'(packet_ready), 32'd0);
        cyc(1'b1, 4, 900, 1'b0, 1'b1, 1'b0);
        chk("t2_ovf_wins", 32'(overflow), 32'd1);
        chk("t2_level_kept", 32'(level), 32'd125);
        cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("t2_ovf_clr", 32'(overflow), 32'd0);
        tick();
        chk("t4_first", audio_out, mk(100));
        send(1, nxt);
        tick();
        send(4, 700);
        chk("t4_full", 32'(level), 32'd128);
        chk("t4_full_ready", 32'(packet_ready), 32'd0);
        for (int k = 0; k < 128; k++) begin
            tick();
            if (k >= 124) chk("t4_wrap_out", audio_out, mk(700 + k - 124));
        end
        chk("t4_empty", 32'(level), 32'd0);

        // Simultaneous write and read, then an over-long count.
        send(4, 300);
        send(4, 304);
        send(2, 308);
        chk("t5_level10", 32'(level), 32'd10);
        cyc(1'b1, 3, 310, 1'b1, 1'b0, 1'b0);
        chk("t5_level12", 32'(level), 32'd12);
        chk("t5_out", audio_out, mk(300));
        send(7, 320);
        chk("t5_clamp", 32'(level), 32'd16);

        // Reset in the middle of a packet at level 40.
        for (int p = 0; p < 6; p++) send(4, 400 + 4 * p);
        chk("t6_level40", 32'(level), 32'd40);
        cyc(1'b1, 4, 500, 1'b1, 1'b0, 1'b1);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_out", audio_out, 32'd0);
        chk("t6_flags", {29'd0, audio_valid, overflow, underflow}, 32'd0);
        tick();
        chk("t6_fill_und", 32'(underflow), 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
